// File: rtl/registru_seq_if.sv
// Command handshake between a command source and the registru_seq sequencer.
interface registru_seq_if #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_arg;
    logic [CW-1:0] cmd_cnt;
    logic          cmd_sat;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_cnt, cmd_sat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_cnt, cmd_sat,
        output cmd_ready
    );
endinterface

// File: rtl/registru_seq.sv
// Command sequencer: expands one command into a burst of one-hot register
// controls, tracking a shadow of the register to stop at saturation bounds.
module registru_seq #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 4
) (
    input  logic         clk,
    input  logic         RESET,
    registru_seq_if.slave cmd,
    output logic         EN,
    output logic         INC,
    output logic         DEC,
    output logic         SHR,
    output logic         SHL,
    output logic [W-1:0] datain,
    output logic [W-1:0] shadow_q,
    output logic         done,
    output logic         sat_hit,
    output logic         err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;

    // Control vector bit order: {SHL, SHR, DEC, INC, EN}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_EN   = 5'b00001;
    localparam logic [4:0] C_INC  = 5'b00010;
    localparam logic [4:0] C_DEC  = 5'b00100;
    localparam logic [4:0] C_SHR  = 5'b01000;
    localparam logic [4:0] C_SHL  = 5'b10000;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sat_q, sat_d;
    logic [4:0]    ctl_q, ctl_d;
    logic [W-1:0]  datain_d;
    logic [W-1:0]  shadow_nxt;
    logic          done_d, sat_hit_d, err_d;

    function automatic logic [4:0] op_ctl(input logic [2:0] op);
        case (op)
            OP_LOAD: return C_EN;
            OP_INC:  return C_INC;
            OP_DEC:  return C_DEC;
            OP_SHR:  return C_SHR;
            OP_SHL:  return C_SHL;
            default: return C_NONE;
        endcase
    endfunction

    function automatic logic at_bound(input logic [2:0] op, input logic [W-1:0] v);
        case (op)
            OP_INC:                 return v == {W{1'b1}};
            OP_DEC, OP_SHR, OP_SHL: return v == '0;
            default:                return 1'b0;
        endcase
    endfunction

    assign cmd.cmd_ready = (state_q == ST_IDLE) && !RESET;
    assign {SHL, SHR, DEC, INC, EN} = ctl_q;

    // Register value after the control currently on the outputs is sampled
    always_comb begin
        shadow_nxt = shadow_q;
        if (ctl_q[0])      shadow_nxt = datain;
        else if (ctl_q[1]) shadow_nxt = shadow_q + W'(1);
        else if (ctl_q[2]) shadow_nxt = shadow_q - W'(1);
        else if (ctl_q[3]) shadow_nxt = shadow_q >> 1;
        else if (ctl_q[4]) shadow_nxt = shadow_q << 1;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        ctl_d     = C_NONE;
        datain_d  = datain;
        done_d    = 1'b0;
        sat_hit_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    op_d  = cmd.cmd_op;
                    cnt_d = cmd.cmd_cnt;
                    sat_d = cmd.cmd_sat;
                    if (cmd.cmd_op == OP_LOAD) begin
                        state_d  = ST_RUN;
                        ctl_d    = C_EN;
                        datain_d = cmd.cmd_arg;
                        cnt_d    = '0;
                    end else if (op_ctl(cmd.cmd_op) == C_NONE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = (cmd.cmd_op != OP_NOP);
                    end else if (cmd.cmd_sat && at_bound(cmd.cmd_op, shadow_q)) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        sat_hit_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        ctl_d   = op_ctl(cmd.cmd_op);
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (sat_q && at_bound(op_q, shadow_nxt)) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        sat_hit_d = 1'b1;
                    end else begin
                        ctl_d = op_ctl(op_q);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; shadow follows the register on every edge
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            ctl_q    <= C_NONE;
            datain   <= '0;
            shadow_q <= '0;
            done     <= 1'b0;
            sat_hit  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            ctl_q    <= ctl_d;
            datain   <= datain_d;
            shadow_q <= shadow_nxt;
            done     <= done_d;
            sat_hit  <= sat_hit_d;
            err      <= err_d;
        end
    end
endmodule

// File: tb/tb_registru_seq.sv
// Scoreboard bench for registru_seq: driver pushes expected results per
// command, a negedge monitor measures each burst and checks it at done.
module tb_registru_seq;
    typedef struct packed {
        logic [4:0] kind;
        logic [7:0] npulse;
        logic [3:0] shadow;
        logic [3:0] din;
        logic       sat;
        logic       err;
    } exp_t;

    localparam logic [4:0] K_NONE = 5'b00000;
    localparam logic [4:0] K_EN   = 5'b00001;
    localparam logic [4:0] K_INC  = 5'b00010;
    localparam logic [4:0] K_DEC  = 5'b00100;
    localparam logic [4:0] K_SHR  = 5'b01000;
    localparam logic [4:0] K_SHL  = 5'b10000;

    logic clk;
    logic RESET;
    logic EN, INC, DEC, SHR, SHL;
    logic [3:0] datain, shadow_q;
    logic done, sat_hit, err;

    registru_seq_if #(.W(4), .CW(4)) bus ();

    registru_seq #(.W(4), .CW(4)) dut (
        .clk     (clk),
        .RESET   (RESET),
        .cmd     (bus),
        .EN      (EN),
        .INC     (INC),
        .DEC     (DEC),
        .SHR     (SHR),
        .SHL     (SHL),
        .datain  (datain),
        .shadow_q(shadow_q),
        .done    (done),
        .sat_hit (sat_hit),
        .err     (err)
    );

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;
    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] k, input int np, input logic [3:0] sh,
                                input logic [3:0] di, input logic s, input logic e);
        exp_t x;
        x.kind = k; x.npulse = 8'(np); x.shadow = sh; x.din = di; x.sat = s; x.err = e;
        return x;
    endfunction

    // Monitor: measure each burst from accept to done and compare with the queue head
    logic       busy = 1'b0;
    int         cyc = 0;
    int         npul = 0;
    logic [4:0] seen = '0;
    always @(negedge clk) begin
        logic [4:0] ctl;
        exp_t e;
        ctl = {SHL, SHR, DEC, INC, EN};
        if (RESET) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                cyc++;
                if (ctl != 5'b0) begin
                    check("onehot", $countones(ctl), 1);
                    npul++;
                    seen = seen | ctl;
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("latency", cyc, int'(e.npulse) + 1);
                    check("pulses", npul, int'(e.npulse));
                    check("pulse_kind", int'(seen), int'(e.kind));
                    check("shadow", int'(shadow_q), int'(e.shadow));
                    check("datain", int'(datain), int'(e.din));
                    check("sat_hit", int'(sat_hit), int'(e.sat));
                    check("err", int'(err), int'(e.err));
                end
                busy = 1'b0;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                busy = 1'b1;
                cyc  = 0;
                npul = 0;
                seen = '0;
                accepts++;
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    // Present a command and return one cycle after it is accepted
    task automatic issue(input logic [2:0] op, input logic [3:0] arg,
                         input logic [3:0] cnt, input logic sat);
        bit ok = 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.cmd_cnt   = cnt;
        bus.cmd_sat   = sat;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1;
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] arg, input logic [3:0] cnt,
                        input logic sat, input exp_t e);
        q.push_back(e);
        issue(op, arg, cnt, sat);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 want=0");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        RESET = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0; bus.cmd_arg = 4'd0; bus.cmd_cnt = 4'd0; bus.cmd_sat = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", int'({SHL, SHR, DEC, INC, EN}), 0);
        check("rst_shadow", int'(shadow_q), 0);
        check("rst_datain", int'(datain), 0);
        check("rst_flags", int'({done, sat_hit, err}), 0);
        @(negedge clk);
        check("rst_ready", int'(bus.cmd_ready), 0);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        RESET = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(bus.cmd_ready), 1);
        check("rst_handshake_ignored", accepts, 0);

        send(3'd1, 4'hA, 4'd9, 1'b0, mk(K_EN,  1, 4'hA, 4'hA, 1'b0, 1'b0));
        send(3'd1, 4'hE, 4'd0, 1'b0, mk(K_EN,  1, 4'hE, 4'hE, 1'b0, 1'b0));
        send(3'd2, 4'h0, 4'd3, 1'b0, mk(K_INC, 4, 4'h2, 4'hE, 1'b0, 1'b0));
        send(3'd1, 4'hD, 4'd0, 1'b0, mk(K_EN,  1, 4'hD, 4'hD, 1'b0, 1'b0));
        send(3'd2, 4'h0, 4'd7, 1'b1, mk(K_INC, 2, 4'hF, 4'hD, 1'b1, 1'b0));
        send(3'd1, 4'h0, 4'd0, 1'b0, mk(K_EN,  1, 4'h0, 4'h0, 1'b0, 1'b0));
        send(3'd3, 4'h0, 4'd0, 1'b1, mk(K_NONE, 0, 4'h0, 4'h0, 1'b1, 1'b0));
        send(3'd1, 4'h3, 4'd0, 1'b0, mk(K_EN,  1, 4'h3, 4'h3, 1'b0, 1'b0));
        send(3'd5, 4'h0, 4'd1, 1'b0, mk(K_SHL, 2, 4'hC, 4'h3, 1'b0, 1'b0));

        // Opcode 7 with cmd_valid held: accepts only every other cycle
        repeat (3) q.push_back(mk(K_NONE, 0, 4'hC, 4'h3, 1'b0, 1'b1));
        a0 = accepts;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd7; bus.cmd_cnt = 4'd4; bus.cmd_sat = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_idle();
        check("held_valid_accepts", accepts - a0, 3);

        send(3'd6, 4'h0, 4'd2, 1'b0, mk(K_NONE, 0, 4'hC, 4'h3, 1'b0, 1'b1));
        send(3'd0, 4'h0, 4'd5, 1'b0, mk(K_NONE, 0, 4'hC, 4'h3, 1'b0, 1'b0));
        send(3'd1, 4'h1, 4'd0, 1'b0, mk(K_EN,  1, 4'h1, 4'h1, 1'b0, 1'b0));
        send(3'd3, 4'h0, 4'd2, 1'b0, mk(K_DEC, 3, 4'hE, 4'h1, 1'b0, 1'b0));
        send(3'd1, 4'h6, 4'd0, 1'b0, mk(K_EN,  1, 4'h6, 4'h6, 1'b0, 1'b0));
        send(3'd4, 4'h0, 4'd7, 1'b1, mk(K_SHR, 3, 4'h0, 4'h6, 1'b1, 1'b0));
        send(3'd1, 4'hD, 4'd0, 1'b0, mk(K_EN,  1, 4'hD, 4'hD, 1'b0, 1'b0));
        send(3'd2, 4'h0, 4'd1, 1'b1, mk(K_INC, 2, 4'hF, 4'hD, 1'b0, 1'b0));
        send(3'd1, 4'h8, 4'd0, 1'b0, mk(K_EN,  1, 4'h8, 4'h8, 1'b0, 1'b0));
        send(3'd4, 4'h0, 4'd2, 1'b0, mk(K_SHR, 3, 4'h1, 4'h8, 1'b0, 1'b0));

        // Reset during the 3rd pulse of INC cnt=5: burst aborted, no done
        issue(3'd2, 4'h0, 4'd5, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("third_pulse_inc", int'(INC), 1);
        RESET = 1'b1;
        @(negedge clk);
        check("ready_in_rst", int'(bus.cmd_ready), 0);
        @(posedge clk); #1;
        RESET = 1'b0;
        check("abort_ctl", int'({SHL, SHR, DEC, INC, EN}), 0);
        check("abort_shadow", int'(shadow_q), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        check("abort_ready", int'(bus.cmd_ready), 1);
        repeat (4) @(negedge clk);

        send(3'd1, 4'h5, 4'd0, 1'b0, mk(K_EN, 1, 4'h5, 4'h5, 1'b0, 1'b0));

        for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
        check("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
